quad_encoder_counter: RTL
=========================

Name: quad_encoder_counter

Overview:
Quadrature decoder and position counter for one wheel encoder channel pair (F/B pins). It feeds the iomem-mapped encoder registers in the SoC top level. The top level instantiates it once per wheel, connecting encoderValue to the read path and writeEncoder/setEncoderData to the write path. It also produces a step-period measurement and an illegal-transition flag for speed estimation and diagnostics.

Parameters:
FILTER_CYCLES, 4, consecutive stable samples required before a pin change is accepted; legal range 1..255.
PERIOD_W, 24, width of the step-period counter and output.
ERR_W, 16, width of the illegal-transition counter.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
pinEncoderF  input  1  raw encoder channel F (asynchronous)
pinEncoderB  input  1  raw encoder channel B (asynchronous)
writeEncoder  input  1  single-cycle load strobe from the bus
setEncoderData  input  32  value loaded into the position count on writeEncoder
encoderValue  output  32  position count, two's complement, wraps modulo 2^32
stepPeriod  output  PERIOD_W  clk cycles between the last two valid steps; saturates
stepDir  output  1  direction of the last valid step: 1 = forward
errCount  output  ERR_W  number of illegal transitions; saturating
errFlag  output  1  sticky illegal-transition flag; cleared by writeEncoder

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - encoderValue=0, stepPeriod=all ones, stepDir=0, errCount=0, errFlag=0.
  - Synchronizers and filtered states are set to 0.
- Synchronizer: each pin passes through a 2-FF synchronizer (sync1, sync2).
- Filter, per channel, independent:
  - stable_cnt (8 bit) resets to 0 whenever sync2 == filt.
  - Otherwise, if stable_cnt == FILTER_CYCLES-1, then filt <= sync2 and stable_cnt <= 0; else stable_cnt increments.
  - A glitch shorter than FILTER_CYCLES cycles is never accepted.
- Decode:
  - prev = {F,B} filtered state registered one cycle earlier; cur = filtered state now.
  - Forward (+1): 00→10→11→01→00.
  - Reverse (−1): the opposite sequence.
  - cur == prev: no step.
  - Both bits changed in the same cycle: illegal. No count change, errFlag <= 1, errCount increments and saturates at 2^ERR_W−1.
- Latency: a clean pin edge captured on clk edge 1 changes encoderValue on edge FILTER_CYCLES+3 (edge 7 with default parameters).
- Count:
  - encoderValue <= encoderValue ± 1 with modulo-2^32 wrap (0xFFFFFFFF +1 → 0; 0 −1 → 0xFFFFFFFF).
  - stepDir updates on every valid step.
- Load:
  - writeEncoder=1 sets encoderValue <= setEncoderData and clears errFlag.
  - The load has priority: a valid step in the same cycle is dropped.
  - errCount is not cleared by a load.
- Period:
  - period_cnt increments every cycle and saturates at 2^PERIOD_W−1.
  - On a valid step: stepPeriod <= period_cnt+1 (saturated), then period_cnt <= 0.
  - When period_cnt reaches saturation, stepPeriod <= 2^PERIOD_W−1 (stall indication) without waiting for a step.
  - Illegal transitions and loads do not affect period.
- Reset asserted mid-operation aborts any pending filter acceptance. No step is generated on reset release, because prev and cur are both 00.
- The outputs are registered and stable between updates, so bus reads need no handshake.

Decomposition:
- Shared package holds:
  - Quadrature state encodings (Q00, Q10, Q11, Q01).
  - Step codes STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL.
  - Default widths.
- One sub-module, enc_pin_filter (2-FF sync plus stable-count filter, parameter FILTER_CYCLES), instantiated per channel.
- Decode, count and period logic stay in quad_encoder_counter.

Test Plan:
- Reset, then 10 forward quadrature cycles, each phase held 20 clk → encoderValue=40, stepDir=1, stepPeriod=20, errFlag=0.
- Load 0x00000000, then one reverse step → encoderValue=0xFFFFFFFF; load 0x7FFFFFFF, then one forward step → 0x80000000.
- 3-cycle pulses on F with FILTER_CYCLES=4 → no count change; a 4-cycle-stable change is accepted, and encoderValue changes exactly on edge 7 after capture.
- Both pins toggle 00→11 simultaneously, held 20 clk → errFlag=1, errCount=1, encoderValue unchanged; writeEncoder with 5 → encoderValue=5, errFlag=0, errCount=1.
- writeEncoder=1 (data 100) in the same cycle as a forward step → encoderValue=100; the step is lost.
- No steps for 2^PERIOD_W cycles (use PERIOD_W=8: 256 cycles) → stepPeriod=255. Reset asserted mid-filter → all outputs at reset values immediately, no step after release.

Source files
------------

// File: rtl/quad_encoder_counter_pkg.sv
// Shared definitions for the quadrature encoder counter: state codes, step codes,
// default widths and the transition classifier used by the decoder.
package quad_encoder_counter_pkg;

    localparam int DEF_FILTER_CYCLES = 4;
    localparam int DEF_PERIOD_W      = 24;
    localparam int DEF_ERR_W         = 16;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q10 = 2'b10,
        Q11 = 2'b11,
        Q01 = 2'b01
    } quad_state_e;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_e;

    // Classify a {F,B} transition; forward order is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] fwd_next;
        step_e      res;
        case (prev)
            Q00:     fwd_next = Q10;
            Q10:     fwd_next = Q11;
            Q11:     fwd_next = Q01;
            Q01:     fwd_next = Q00;
            default: fwd_next = Q10;
        endcase
        if (prev == cur) begin
            res = STEP_NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            res = STEP_ILLEGAL;
        end else if (cur == fwd_next) begin
            res = STEP_FWD;
        end else begin
            res = STEP_REV;
        end
        return res;
    endfunction

endpackage

// File: rtl/quad_encoder_counter_enc_pin_filter.sv
// One encoder pin: two-flop synchronizer followed by a stable-count glitch filter.
module enc_pin_filter
    import quad_encoder_counter_pkg::*;
#(
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic filt_o
);

    localparam logic [7:0] LAST_CNT = 8'(FILTER_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic       filt_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // A new level is taken only after FILTER_CYCLES consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync2_q == filt_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == LAST_CNT) begin
            filt_d = sync2_q;
            cnt_d  = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Synchronizer and filter state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature decoder with position count, step-period measurement and
// illegal-transition diagnostics for one wheel encoder.
module quad_encoder_counter
    import quad_encoder_counter_pkg::*;
#(
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int PERIOD_W      = DEF_PERIOD_W,
    parameter int ERR_W         = DEF_ERR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pinEncoderF,
    input  logic                pinEncoderB,
    input  logic                writeEncoder,
    input  logic [31:0]         setEncoderData,
    output logic [31:0]         encoderValue,
    output logic [PERIOD_W-1:0] stepPeriod,
    output logic                stepDir,
    output logic [ERR_W-1:0]    errCount,
    output logic                errFlag
);

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]    ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0]    ERR_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};

    logic                f_filt_s;
    logic                b_filt_s;
    logic [1:0]          cur_s;
    logic [1:0]          prev_q;
    step_e               step_s;
    logic                step_valid_s;

    logic [31:0]         value_q,       value_d;
    logic [PERIOD_W-1:0] period_cnt_q,  period_cnt_d;
    logic [PERIOD_W-1:0] step_period_q, step_period_d;
    logic                dir_q,         dir_d;
    logic [ERR_W-1:0]    err_cnt_q,     err_cnt_d;
    logic                err_flag_q,    err_flag_d;

    enc_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_f (
        .clk_i   (clk),
        .reset_i (reset),
        .pin_i   (pinEncoderF),
        .filt_o  (f_filt_s)
    );

    enc_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
        .clk_i   (clk),
        .reset_i (reset),
        .pin_i   (pinEncoderB),
        .filt_o  (b_filt_s)
    );

    assign cur_s        = {f_filt_s, b_filt_s};
    assign step_s       = decode_step(prev_q, cur_s);
    assign step_valid_s = (step_s == STEP_FWD) || (step_s == STEP_REV);

    // Position, direction and error bookkeeping; a bus load overrides a same-cycle step.
    always_comb begin
        value_d    = value_q;
        dir_d      = dir_q;
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        if (writeEncoder) begin
            value_d    = setEncoderData;
            err_flag_d = 1'b0;
        end else if (step_s == STEP_FWD) begin
            value_d = value_q + 32'd1;
            dir_d   = 1'b1;
        end else if (step_s == STEP_REV) begin
            value_d = value_q - 32'd1;
            dir_d   = 1'b0;
        end else if (step_s == STEP_ILLEGAL) begin
            err_flag_d = 1'b1;
        end else begin
            value_d = value_q;
        end
        if ((step_s == STEP_ILLEGAL) && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Step-period measurement; a saturated counter reports a stall without waiting for a step.
    always_comb begin
        period_cnt_d  = period_cnt_q;
        step_period_d = step_period_q;
        if (step_valid_s) begin
            step_period_d = (period_cnt_q == PERIOD_MAX) ? PERIOD_MAX : period_cnt_q + PERIOD_ONE;
            period_cnt_d  = {PERIOD_W{1'b0}};
        end else if (period_cnt_q == PERIOD_MAX) begin
            step_period_d = PERIOD_MAX;
            period_cnt_d  = PERIOD_MAX;
        end else begin
            period_cnt_d  = period_cnt_q + PERIOD_ONE;
        end
    end

    // Decoder history and all output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q        <= 2'b00;
            value_q       <= 32'd0;
            period_cnt_q  <= {PERIOD_W{1'b0}};
            step_period_q <= PERIOD_MAX;
            dir_q         <= 1'b0;
            err_cnt_q     <= {ERR_W{1'b0}};
            err_flag_q    <= 1'b0;
        end else begin
            prev_q        <= cur_s;
            value_q       <= value_d;
            period_cnt_q  <= period_cnt_d;
            step_period_q <= step_period_d;
            dir_q         <= dir_d;
            err_cnt_q     <= err_cnt_d;
            err_flag_q    <= err_flag_d;
        end
    end

    assign encoderValue = value_q;
    assign stepPeriod   = step_period_q;
    assign stepDir      = dir_q;
    assign errCount     = err_cnt_q;
    assign errFlag      = err_flag_q;

endmodule
